i2c_register_bank: RTL and testbench
====================================

Name: i2c_register_bank

Overview:
- Parametrised memory-mapped register bank for the I2C master peripheral; replaces the flat native register signal bundle.
- Holds configuration registers and sticky W1C status bits.
- Contains TX (data_out) and RX (data_in) FIFOs of configurable depth, transfer byte counters and a single aggregated interrupt.
- Sits between the host bus adapter and the I2C master core.

Parameters:
DATA_WIDTH, 8, I2C byte width carried through the FIFOs
LEN_WIDTH, 32, width of the length registers and byte counters (max 32)
TX_DEPTH, 4, TX FIFO entries (power of two, >=2)
RX_DEPTH, 4, RX FIFO entries (power of two, >=2)
ADDR_WIDTH, 4, bus word-address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
bus_wr_en  in  1  register write strobe
bus_rd_en  in  1  register read strobe
bus_addr  in  ADDR_WIDTH  word address
bus_wdata  in  32  write data
bus_rdata  out  32  read data, valid with bus_rvalid
bus_rvalid  out  1  read-data-valid pulse
tx_valid  out  1  TX FIFO not empty
tx_data  out  DATA_WIDTH  TX FIFO head
tx_pop  in  1  core consumes TX head
rx_push  in  1  core delivers a received byte
rx_data  in  DATA_WIDTH  received byte
evt_stop, evt_ack, evt_nack, evt_arb_loss  in  1 each  single-cycle core event pulses
bus_available_in  in  1  live bus-free level
byte_read_inc, byte_written_inc  in  1 each  byte counter increments
start_pulse  out  1  one-cycle transfer start
read_length, write_length  out  LEN_WIDTH  length registers
clk_divider  out  16  SCL divider
fifo_enable, packet_type, master_ack, master_nack, sr_enable  out  1 each  config bits
irq  out  1  level interrupt

Behaviour:
- Reset: all registers, FIFO pointers, counters and sticky bits 0; irq=0; bus_rdata=0; bus_rvalid=0; start_pulse=0.
- Address map:
  - 0 DATA: write pushes wdata[DATA_WIDTH-1:0] into TX; read pops RX.
  - 1 READ_LEN; 2 WRITE_LEN; 3 CLK_DIV[15:0].
  - 4 CONFIG: [7:0] IRQ enables (stop, rx_full, rx_empty, tx_full, ack, nack, bus, arb); 8 fifo_enable; 9 packet_type; 10 start; 11 master_ack; 12 master_nack; 13 sr_enable.
  - 5 STATUS: [0] stop, [1] ack, [2] nack, [3] arb_loss, [4] tx_overflow (sticky, write-1-to-clear); [5] rx_full, [6] rx_empty, [7] tx_full, [8] tx_empty, [9] bus_available (read-only live).
  - 6 BYTES_READ; 7 BYTES_WRITTEN (read-only).
  - Unmapped addresses read 0; writes to them are ignored.
- Read latency: exactly 1 cycle. bus_rdata and bus_rvalid are registered; bus_rvalid pulses 1 cycle after bus_rd_en. bus_rdata holds its value otherwise.
- CONFIG bit 10 is not stored; it always reads 0. Writing 1 asserts start_pulse for exactly one cycle, on the cycle after the write. The same start also clears both byte counters.
- Byte counters increment on their strobe and wrap at 2^LEN_WIDTH. If a start clear and an increment coincide, the clear wins.
- FIFOs use read/write pointers plus one extra wrap bit.
- TX full push: data is dropped and tx_overflow is set.
- RX full push: data is dropped; no flag.
- Pop when empty: no pointer change; a DATA read with RX empty returns 0.
- Simultaneous push and pop on a non-empty, non-full FIFO: occupancy unchanged.
- Simultaneous push and pop on a full TX FIFO: the pop occurs and the push succeeds.
- When fifo_enable=0, effective depth is 1: full when occupancy is >=1.
- Sticky bits: a hardware event and a W1C on the same bit in the same cycle leave the bit set (set wins).
- irq is registered and equals the OR of each (enable & source), where the sources are stop, rx_full, rx_empty, tx_full, ack, nack, bus_available and arb_loss.
- Reset mid-transfer flushes both FIFOs and drops any pending start.

Optional Feature:
- Macro I2C_REGS_WATERMARK_EN.
- When defined:
  - Adds address 8 WATERMARK: [7:0] tx_low_mark, [15:8] rx_high_mark (R/W); [23:16] tx_level, [31:24] rx_level (read-only).
  - Adds CONFIG[14] wm_ire.
  - irq additionally includes wm_ire & (tx_level <= tx_low_mark | rx_level >= rx_high_mark).
- When not defined: address 8 reads 0, CONFIG[14] reads 0, and no watermark logic is generated.

Test Plan:
- Reset low for 2 cycles, then read addresses 0–7 -> all return 0 except STATUS = 0x140 (rx_empty, tx_empty); irq=0.
- Write DATA 0xA1..0xA5 with TX_DEPTH=4 -> tx_full=1, tx_overflow=1; four tx_pop pulses yield A1, A2, A3, A4, then tx_valid=0.
- rx_push 0x3C, then DATA read -> bus_rvalid one cycle later with rdata=0x3C; a second read returns 0 and rx_empty stays 1.
- Write CONFIG=0x0400 after byte_written_inc x3 -> start_pulse high for exactly 1 cycle; BYTES_WRITTEN reads 0 afterwards; CONFIG reads 0.
- Enable nack IRQ (CONFIG=0x20); pulse evt_nack together with a W1C to STATUS bit 2 -> nack stays 1 and irq=1; a later W1C alone clears nack and drops irq the next cycle.
- fifo_enable=0: write DATA twice -> second write is dropped, tx_overflow=1, tx_data equals the first byte.

Source files
------------

// File: rtl/i2c_register_bank.sv
// Memory-mapped register bank for the I2C master: config, W1C status, TX/RX FIFOs, byte counters, irq.
// Optional watermark register and interrupt enabled by defining I2C_REGS_WATERMARK_EN.
module i2c_register_bank #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 32,
  parameter int unsigned TX_DEPTH   = 4,
  parameter int unsigned RX_DEPTH   = 4,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bus_wr_en,
  input  logic                  bus_rd_en,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [31:0]           bus_wdata,
  output logic [31:0]           bus_rdata,
  output logic                  bus_rvalid,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_pop,
  input  logic                  rx_push,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  evt_stop,
  input  logic                  evt_ack,
  input  logic                  evt_nack,
  input  logic                  evt_arb_loss,
  input  logic                  bus_available_in,
  input  logic                  byte_read_inc,
  input  logic                  byte_written_inc,
  output logic                  start_pulse,
  output logic [LEN_WIDTH-1:0]  read_length,
  output logic [LEN_WIDTH-1:0]  write_length,
  output logic [15:0]           clk_divider,
  output logic                  fifo_enable,
  output logic                  packet_type,
  output logic                  master_ack,
  output logic                  master_nack,
  output logic                  sr_enable,
  output logic                  irq
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);

  localparam logic [ADDR_WIDTH-1:0] A_DATA     = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_READ_LEN = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_WRIT_LEN = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_CLK_DIV  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_CONFIG   = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS   = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] A_BYTES_RD = ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] A_BYTES_WR = ADDR_WIDTH'(7);
`ifdef I2C_REGS_WATERMARK_EN
  localparam logic [ADDR_WIDTH-1:0] A_WMARK    = ADDR_WIDTH'(8);
`endif

  logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
  logic [TX_AW:0] tx_wptr, tx_rptr, tx_wptr_nxt, tx_rptr_nxt, tx_count, tx_count_nxt;
  logic [RX_AW:0] rx_wptr, rx_rptr, rx_wptr_nxt, rx_rptr_nxt, rx_count, rx_count_nxt;
  logic tx_empty, tx_full, tx_full_nxt, rx_empty, rx_full, rx_empty_nxt, rx_full_nxt;
  logic tx_push_ok, tx_pop_ok, rx_push_ok, rx_pop_ok, tx_ovf_evt;
  logic wr_data, rd_data, wr_config, wr_status, start_wr;

  logic [7:0]           irq_en;
  logic [4:0]           sticky, sticky_nxt, w1c, evt;
  logic [7:0]           irq_src_nxt;
  logic                 irq_nxt;
  logic [LEN_WIDTH-1:0] bytes_read, bytes_written;
  logic [31:0]          rdata_c, cfg_rd;
`ifdef I2C_REGS_WATERMARK_EN
  logic       wm_ire;
  logic [7:0] tx_low_mark, rx_high_mark;
`endif

  // Decode, FIFO bookkeeping, sticky/irq next state and read mux
  always_comb begin
    wr_data   = bus_wr_en && (bus_addr == A_DATA);
    rd_data   = bus_rd_en && (bus_addr == A_DATA);
    wr_config = bus_wr_en && (bus_addr == A_CONFIG);
    wr_status = bus_wr_en && (bus_addr == A_STATUS);
    start_wr  = wr_config && bus_wdata[10];

    // With the FIFO disabled the effective depth collapses to one entry
    tx_count = tx_wptr - tx_rptr;
    tx_empty = (tx_count == '0);
    tx_full  = fifo_enable ? (tx_count == TX_FULL_CNT) : !tx_empty;
    rx_count = rx_wptr - rx_rptr;
    rx_empty = (rx_count == '0);
    rx_full  = fifo_enable ? (rx_count == RX_FULL_CNT) : !rx_empty;

    tx_pop_ok  = tx_pop && !tx_empty;
    tx_push_ok = wr_data && (!tx_full || tx_pop_ok);
    tx_ovf_evt = wr_data && tx_full && !tx_pop_ok;
    rx_pop_ok  = rd_data && !rx_empty;
    rx_push_ok = rx_push && !rx_full;

    tx_wptr_nxt  = tx_wptr + (TX_AW+1)'(tx_push_ok);
    tx_rptr_nxt  = tx_rptr + (TX_AW+1)'(tx_pop_ok);
    rx_wptr_nxt  = rx_wptr + (RX_AW+1)'(rx_push_ok);
    rx_rptr_nxt  = rx_rptr + (RX_AW+1)'(rx_pop_ok);
    tx_count_nxt = tx_wptr_nxt - tx_rptr_nxt;
    rx_count_nxt = rx_wptr_nxt - rx_rptr_nxt;
    tx_full_nxt  = fifo_enable ? (tx_count_nxt == TX_FULL_CNT) : (tx_count_nxt != '0);
    rx_empty_nxt = (rx_count_nxt == '0);
    rx_full_nxt  = fifo_enable ? (rx_count_nxt == RX_FULL_CNT) : !rx_empty_nxt;

    // Hardware events win over a simultaneous write-1-to-clear
    w1c        = wr_status ? bus_wdata[4:0] : 5'd0;
    evt        = {tx_ovf_evt, evt_arb_loss, evt_nack, evt_ack, evt_stop};
    sticky_nxt = (sticky & ~w1c) | evt;

    irq_src_nxt = {sticky_nxt[3], bus_available_in, sticky_nxt[2], sticky_nxt[1],
                   tx_full_nxt, rx_empty_nxt, rx_full_nxt, sticky_nxt[0]};
    irq_nxt     = |(irq_en & irq_src_nxt);
`ifdef I2C_REGS_WATERMARK_EN
    irq_nxt = irq_nxt || (wm_ire && ((8'(tx_count_nxt) <= tx_low_mark) ||
                                     (8'(rx_count_nxt) >= rx_high_mark)));
`endif

    cfg_rd       = 32'd0;
    cfg_rd[7:0]  = irq_en;
    cfg_rd[8]    = fifo_enable;
    cfg_rd[9]    = packet_type;
    cfg_rd[11]   = master_ack;
    cfg_rd[12]   = master_nack;
    cfg_rd[13]   = sr_enable;
`ifdef I2C_REGS_WATERMARK_EN
    cfg_rd[14]   = wm_ire;
`endif

    rdata_c = 32'd0;
    case (bus_addr)
      A_DATA:     rdata_c = rx_empty ? 32'd0 : 32'(rx_mem[rx_rptr[RX_AW-1:0]]);
      A_READ_LEN: rdata_c = 32'(read_length);
      A_WRIT_LEN: rdata_c = 32'(write_length);
      A_CLK_DIV:  rdata_c = 32'(clk_divider);
      A_CONFIG:   rdata_c = cfg_rd;
      A_STATUS:   rdata_c = {22'd0, bus_available_in, tx_empty, tx_full, rx_empty, rx_full, sticky};
      A_BYTES_RD: rdata_c = 32'(bytes_read);
      A_BYTES_WR: rdata_c = 32'(bytes_written);
`ifdef I2C_REGS_WATERMARK_EN
      A_WMARK:    rdata_c = {8'(rx_count), 8'(tx_count), rx_high_mark, tx_low_mark};
`endif
      default:    rdata_c = 32'd0;
    endcase
  end

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[tx_rptr[TX_AW-1:0]];

  // FIFO storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wptr[TX_AW-1:0]] <= bus_wdata[DATA_WIDTH-1:0];
    if (rx_push_ok) rx_mem[rx_wptr[RX_AW-1:0]] <= rx_data;
  end

  // Control registers, pointers, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_wptr       <= '0;
      tx_rptr       <= '0;
      rx_wptr       <= '0;
      rx_rptr       <= '0;
      sticky        <= '0;
      irq_en        <= '0;
      fifo_enable   <= 1'b0;
      packet_type   <= 1'b0;
      master_ack    <= 1'b0;
      master_nack   <= 1'b0;
      sr_enable     <= 1'b0;
      read_length   <= '0;
      write_length  <= '0;
      clk_divider   <= '0;
      bytes_read    <= '0;
      bytes_written <= '0;
      start_pulse   <= 1'b0;
      irq           <= 1'b0;
      bus_rdata     <= '0;
      bus_rvalid    <= 1'b0;
`ifdef I2C_REGS_WATERMARK_EN
      wm_ire        <= 1'b0;
      tx_low_mark   <= '0;
      rx_high_mark  <= '0;
`endif
    end else begin
      tx_wptr     <= tx_wptr_nxt;
      tx_rptr     <= tx_rptr_nxt;
      rx_wptr     <= rx_wptr_nxt;
      rx_rptr     <= rx_rptr_nxt;
      sticky      <= sticky_nxt;
      irq         <= irq_nxt;
      start_pulse <= start_wr;
      bus_rvalid  <= bus_rd_en;
      if (bus_rd_en) bus_rdata <= rdata_c;

      if (bus_wr_en) begin
        case (bus_addr)
          A_READ_LEN: read_length  <= LEN_WIDTH'(bus_wdata);
          A_WRIT_LEN: write_length <= LEN_WIDTH'(bus_wdata);
          A_CLK_DIV:  clk_divider  <= bus_wdata[15:0];
          A_CONFIG: begin
            irq_en      <= bus_wdata[7:0];
            fifo_enable <= bus_wdata[8];
            packet_type <= bus_wdata[9];
            master_ack  <= bus_wdata[11];
            master_nack <= bus_wdata[12];
            sr_enable   <= bus_wdata[13];
`ifdef I2C_REGS_WATERMARK_EN
            wm_ire      <= bus_wdata[14];
`endif
          end
`ifdef I2C_REGS_WATERMARK_EN
          A_WMARK: begin
            tx_low_mark  <= bus_wdata[7:0];
            rx_high_mark <= bus_wdata[15:8];
          end
`endif
          default: ;
        endcase
      end

      // A start clear takes priority over a coincident increment
      if (start_wr) begin
        bytes_read    <= '0;
        bytes_written <= '0;
      end else begin
        bytes_read    <= bytes_read + LEN_WIDTH'(byte_read_inc);
        bytes_written <= bytes_written + LEN_WIDTH'(byte_written_inc);
      end
    end
  end

endmodule

// File: tb/tb_i2c_register_bank.sv
// Directed bench for i2c_register_bank: register table plus FIFO, W1C, start and irq sequences.
module tb_i2c_register_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_wr_en, bus_rd_en;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_rvalid;
  logic        tx_valid, tx_pop, rx_push;
  logic [7:0]  tx_data, rx_data;
  logic        evt_stop, evt_ack, evt_nack, evt_arb_loss, bus_available_in;
  logic        byte_read_inc, byte_written_inc, start_pulse;
  logic [31:0] read_length, write_length;
  logic [15:0] clk_divider;
  logic        fifo_enable, packet_type, master_ack, master_nack, sr_enable, irq;

  int n_checks = 0;
  int n_fail   = 0;

  i2c_register_bank dut (
    .clk(clk), .reset(reset), .bus_wr_en(bus_wr_en), .bus_rd_en(bus_rd_en),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_pop(tx_pop), .rx_push(rx_push), .rx_data(rx_data),
    .evt_stop(evt_stop), .evt_ack(evt_ack), .evt_nack(evt_nack), .evt_arb_loss(evt_arb_loss),
    .bus_available_in(bus_available_in), .byte_read_inc(byte_read_inc),
    .byte_written_inc(byte_written_inc), .start_pulse(start_pulse), .read_length(read_length),
    .write_length(write_length), .clk_divider(clk_divider), .fifo_enable(fifo_enable),
    .packet_type(packet_type), .master_ack(master_ack), .master_nack(master_nack),
    .sr_enable(sr_enable), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_wr_en = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_wr_en = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus_rd_en = 1'b1; bus_addr = a;
    @(negedge clk);
    bus_rd_en = 1'b0;
    check({name, "_rvalid"}, 32'(bus_rvalid), 32'd1);
    check(name, bus_rdata, exp);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    @(negedge clk);
    check({name, "_valid"}, 32'(tx_valid), 32'd1);
    check(name, 32'(tx_data), 32'(exp));
    tx_pop = 1'b1;
    @(negedge clk);
    tx_pop = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] d);
    @(negedge clk);
    rx_push = 1'b1; rx_data = d;
    @(negedge clk);
    rx_push = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b0, 4'(i), 32'd0, (i == 5) ? 32'h140 : 32'd0};
    vecs[8]  = '{1'b0, 4'd8,  32'd0,         32'd0};
    vecs[9]  = '{1'b1, 4'd1,  32'h12345678,  32'd0};
    vecs[10] = '{1'b0, 4'd1,  32'd0,         32'h12345678};
    vecs[11] = '{1'b1, 4'd2,  32'hDEADBEEF,  32'd0};
    vecs[12] = '{1'b0, 4'd2,  32'd0,         32'hDEADBEEF};
    vecs[13] = '{1'b1, 4'd3,  32'hFFFFABCD,  32'd0};
    vecs[14] = '{1'b0, 4'd3,  32'd0,         32'h0000ABCD};
    vecs[15] = '{1'b1, 4'd4,  32'h00003B05,  32'd0};
    vecs[16] = '{1'b0, 4'd4,  32'd0,         32'h00003B05};
    vecs[17] = '{1'b1, 4'd6,  32'h0000FFFF,  32'd0};
    vecs[18] = '{1'b0, 4'd6,  32'd0,         32'd0};
    vecs[19] = '{1'b1, 4'd15, 32'h00001234,  32'd0};
    vecs[20] = '{1'b0, 4'd15, 32'd0,         32'd0};

    reset = 1'b0; bus_wr_en = 1'b0; bus_rd_en = 1'b0; bus_addr = '0; bus_wdata = '0;
    tx_pop = 1'b0; rx_push = 1'b0; rx_data = '0;
    evt_stop = 1'b0; evt_ack = 1'b0; evt_nack = 1'b0; evt_arb_loss = 1'b0;
    bus_available_in = 1'b0; byte_read_inc = 1'b0; byte_written_inc = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_start", 32'(start_pulse), 32'd0);
    check("reset_rvalid", 32'(bus_rvalid), 32'd0);
    check("reset_rdata", bus_rdata, 32'd0);
    check("reset_tx_valid", 32'(tx_valid), 32'd0);

    // Register map table
    for (int i = 0; i < 21; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      else read_check($sformatf("vec%0d_a%0d", i, vecs[i].addr), vecs[i].addr, vecs[i].exp_rdata);
    end
    check("read_length_port", read_length, 32'h12345678);
    check("write_length_port", write_length, 32'hDEADBEEF);
    check("clk_divider_port", 32'(clk_divider), 32'h0000ABCD);
    check("cfg_ports", {27'd0, fifo_enable, packet_type, master_ack, master_nack, sr_enable}, 32'h1F);
    check("irq_rx_empty_en", 32'(irq), 32'd1);
    bus_write(4'd4, 32'h0100);

    // TX overflow and drain
    for (int i = 0; i < 5; i++) bus_write(4'd0, 32'(8'hA1 + i));
    read_check("tx_full_status", 4'd5, 32'h0D0);
    for (int i = 0; i < 4; i++) pop_check($sformatf("tx_pop%0d", i), 8'(8'hA1 + i));
    check("tx_drained", 32'(tx_valid), 32'd0);
    bus_write(4'd5, 32'h10);
    read_check("tx_ovf_cleared", 4'd5, 32'h140);

    // RX single byte, then empty read
    rx_send(8'h3C);
    read_check("rx_data", 4'd0, 32'h3C);
    @(negedge clk);
    check("rvalid_pulse", 32'(bus_rvalid), 32'd0);
    read_check("rx_empty_read", 4'd0, 32'd0);
    read_check("rx_empty_status", 4'd5, 32'h140);

    // RX full: fifth byte dropped
    for (int i = 0; i < 5; i++) rx_send(8'(8'h10 + i));
    read_check("rx_full_status", 4'd5, 32'h120);
    for (int i = 0; i < 4; i++) read_check($sformatf("rx_rd%0d", i), 4'd0, 32'(8'h10 + i));
    read_check("rx_after_drop", 4'd0, 32'd0);

    // TX full with simultaneous push and pop
    for (int i = 0; i < 4; i++) bus_write(4'd0, 32'(8'hB0 + i));
    @(negedge clk);
    bus_wr_en = 1'b1; bus_addr = 4'd0; bus_wdata = 32'h99; tx_pop = 1'b1;
    @(negedge clk);
    bus_wr_en = 1'b0; tx_pop = 1'b0;
    read_check("full_pushpop_status", 4'd5, 32'h0C0);
    for (int i = 1; i < 4; i++) pop_check($sformatf("pp_pop%0d", i), 8'(8'hB0 + i));
    pop_check("pp_pop_new", 8'h99);

    // Byte counters and start pulse; clear beats a coincident increment
    @(negedge clk);
    byte_written_inc = 1'b1; byte_read_inc = 1'b1;
    @(negedge clk); @(negedge clk);
    byte_read_inc = 1'b0;
    @(negedge clk);
    byte_written_inc = 1'b0;
    read_check("bytes_written_3", 4'd7, 32'd3);
    read_check("bytes_read_2", 4'd6, 32'd2);
    @(negedge clk);
    byte_written_inc = 1'b1;
    bus_wr_en = 1'b1; bus_addr = 4'd4; bus_wdata = 32'h0400;
    @(negedge clk);
    bus_wr_en = 1'b0; byte_written_inc = 1'b0;
    check("start_high", 32'(start_pulse), 32'd1);
    @(negedge clk);
    check("start_one_cycle", 32'(start_pulse), 32'd0);
    read_check("bytes_written_clr", 4'd7, 32'd0);
    read_check("bytes_read_clr", 4'd6, 32'd0);
    read_check("config_start_rd0", 4'd4, 32'd0);

    // Nack event vs. W1C in the same cycle
    bus_write(4'd4, 32'h20);
    @(negedge clk);
    evt_nack = 1'b1; bus_wr_en = 1'b1; bus_addr = 4'd5; bus_wdata = 32'h4;
    @(negedge clk);
    evt_nack = 1'b0; bus_wr_en = 1'b0;
    check("nack_irq_set", 32'(irq), 32'd1);
    read_check("nack_sticky", 4'd5, 32'h144);
    bus_write(4'd5, 32'h4);
    check("nack_irq_clr", 32'(irq), 32'd0);
    read_check("nack_cleared", 4'd5, 32'h140);

    // Depth-1 mode when the FIFO is disabled
    bus_write(4'd0, 32'h55);
    bus_write(4'd0, 32'h66);
    read_check("depth1_status", 4'd5, 32'h0D0);
    pop_check("depth1_head", 8'h55);
    check("depth1_empty", 32'(tx_valid), 32'd0);
    bus_write(4'd5, 32'h10);

    // Live bus_available status and interrupt
    bus_write(4'd4, 32'h40);
    @(negedge clk);
    bus_available_in = 1'b1;
    @(negedge clk);
    check("bus_irq_set", 32'(irq), 32'd1);
    read_check("bus_avail_status", 4'd5, 32'h340);
    @(negedge clk);
    bus_available_in = 1'b0;
    @(negedge clk);
    check("bus_irq_clr", 32'(irq), 32'd0);

    // Reset in the middle of a transfer, coinciding with a start write
    bus_write(4'd4, 32'h0100);
    bus_write(4'd0, 32'h77);
    rx_send(8'h88);
    check("pre_reset_tx_valid", 32'(tx_valid), 32'd1);
    @(negedge clk);
    reset = 1'b0; bus_wr_en = 1'b1; bus_addr = 4'd4; bus_wdata = 32'h0400;
    @(negedge clk);
    bus_wr_en = 1'b0;
    check("reset_drops_start", 32'(start_pulse), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_flush_tx", 32'(tx_valid), 32'd0);
    read_check("reset_flush_status", 4'd5, 32'h140);
    read_check("reset_config", 4'd4, 32'd0);
    read_check("reset_rx_data", 4'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
